// File: rtl/sat_round_narrow.sv
// sat_round_narrow
//   Multi-lane narrowing stage. Each signed IN_W-bit lane gets a rounding
//   arithmetic right shift (round-half-up), an optional ReLU, and a
//   saturation to the signed OUT_W range. The block is a two-stage pipeline
//   with valid/ready handshakes on both sides, and it keeps a running count
//   of lanes that had to be clamped.
//
// Ports
//   clk       : clock, rising edge active
//   rst_n     : asynchronous reset, active low
//   in_valid  : input word valid
//   in_ready  : block accepts the input word this cycle
//   in_data   : LANES packed signed lanes, lane k at [k*IN_W +: IN_W]
//   relu_en   : zero negative results; sampled together with in_data
//   out_valid : output word valid
//   out_ready : downstream accepts the output word
//   out_data  : LANES packed signed lanes, lane k at [k*OUT_W +: OUT_W]
//   sat_cnt   : saturating count of clamped lanes
//   sat_clr   : synchronous clear of sat_cnt, wins over an increment
module sat_round_narrow #(
  parameter int LANES = 4,
  parameter int IN_W  = 18,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  input  logic                   relu_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [CNT_W-1:0]       sat_cnt,
  input  logic                   sat_clr
);

  // Width needed to hold a per-word count of saturated lanes (0..LANES).
  localparam int NS_W  = $clog2(LANES + 1);
  // Counter adder is wide enough that sat_cnt + n_sat can never wrap.
  localparam int SUM_W = ((CNT_W > NS_W) ? CNT_W : NS_W) + 1;

  // Half an LSB of the shifted result; zero when no shift is applied.
  localparam logic signed [IN_W:0] RND     = (IN_W+1)'((1 << SHIFT) >> 1);
  localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'((1 << (OUT_W-1)) - 1);
  // Bitwise inverse of 2^(OUT_W-1)-1 is -2^(OUT_W-1).
  localparam logic signed [IN_W:0] SAT_MIN = ~SAT_MAX;
  localparam logic [CNT_W-1:0]     CNT_MAX = '1;

  logic                   pipe_en;
  logic                   v1;
  logic                   v2;
  logic                   relu1;
  logic signed [IN_W:0]   x_ext   [LANES];
  logic signed [IN_W:0]   r_next  [LANES];
  logic signed [IN_W:0]   r1      [LANES];
  logic [OUT_W-1:0]       lane_out[LANES];
  logic [LANES-1:0]       sat_hit;
  logic [NS_W-1:0]        n_sat;
  logic [SUM_W-1:0]       cnt_sum;
  logic [CNT_W-1:0]       cnt_next;
  logic [CNT_W-1:0]       cnt_q;
  logic [LANES*OUT_W-1:0] out_q;

  // Whole pipeline advances together; it only stalls when the output slot
  // is full and downstream is not taking it.
  assign pipe_en   = !v2 || out_ready;
  assign in_ready  = pipe_en;
  assign out_valid = v2;
  assign out_data  = out_q;
  assign sat_cnt   = cnt_q;

  // Stage 1 datapath: sign-extend by one bit so the rounding add cannot
  // overflow, then arithmetic shift.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      x_ext[k]  = $signed({in_data[k*IN_W + IN_W - 1], in_data[k*IN_W +: IN_W]});
      r_next[k] = (x_ext[k] + RND) >>> SHIFT;
    end
  end

  // Stage 2 datapath: clamp each lane, then apply ReLU on the clamped value.
  // Only the clamp counts as a saturation event.
  always_comb begin
    sat_hit = '0;
    n_sat   = '0;
    for (int k = 0; k < LANES; k++) begin
      if (r1[k] > SAT_MAX) begin
        lane_out[k] = SAT_MAX[OUT_W-1:0];
        sat_hit[k]  = 1'b1;
      end else if (r1[k] < SAT_MIN) begin
        lane_out[k] = SAT_MIN[OUT_W-1:0];
        sat_hit[k]  = 1'b1;
      end else begin
        lane_out[k] = r1[k][OUT_W-1:0];
      end
      if (relu1 && lane_out[k][OUT_W-1]) begin
        lane_out[k] = '0;
      end
      n_sat = n_sat + NS_W'(sat_hit[k]);
    end
  end

  // Saturating accumulate of the event count.
  always_comb begin
    cnt_sum  = SUM_W'(cnt_q) + SUM_W'(n_sat);
    cnt_next = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
  end

  // Stage 1 registers: valid, ReLU flag and the rounded/shifted lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      relu1 <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        r1[k] <= '0;
      end
    end else if (pipe_en) begin
      v1    <= in_valid;
      relu1 <= relu_en;
      for (int k = 0; k < LANES; k++) begin
        r1[k] <= r_next[k];
      end
    end
  end

  // Stage 2 registers: output valid and the narrowed lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      out_q <= '0;
    end else if (pipe_en) begin
      v2 <= v1;
      for (int k = 0; k < LANES; k++) begin
        out_q[k*OUT_W +: OUT_W] <= lane_out[k];
      end
    end
  end

  // A word is counted exactly once, on the edge where it moves into stage 2.
  // Bubbles (v1=0) and held words never add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (sat_clr) begin
      cnt_q <= '0;
    end else if (pipe_en && v1) begin
      cnt_q <= cnt_next;
    end
  end

endmodule

// File: tb/tb_sat_round_narrow.sv
// Testbench for sat_round_narrow. Three instances share all inputs:
// defaults (dut0), SHIFT=2 (dut_s) and CNT_W=2 (dut_c). Accepted words are
// modelled and pushed to a scoreboard; a monitor pops and compares on every
// output transfer and also checks that a stalled output word holds still.
module tb_sat_round_narrow;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [71:0] in_data;
  logic        relu_en;
  logic        out_ready;
  logic        sat_clr;

  logic        in_ready0, in_ready_s, in_ready_c;
  logic        out_valid0, out_valid_s, out_valid_c;
  logic [63:0] out_data0, out_data_s, out_data_c;
  logic [15:0] sat_cnt0, sat_cnt_s;
  logic [1:0]  sat_cnt_c;

  typedef struct packed {
    logic [63:0] d0;
    logic [63:0] d2;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_out    = 0;
  int          cnt0 = 0, cnt_s = 0, cnt_c = 0;
  logic        ready_force = 1'b0;
  logic        rand_ready  = 1'b0;
  logic        held = 1'b0;
  logic [63:0] held_d;

  sat_round_narrow #(.LANES(4), .IN_W(18), .OUT_W(16), .SHIFT(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .relu_en(relu_en), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .sat_cnt(sat_cnt0), .sat_clr(sat_clr));

  sat_round_narrow #(.LANES(4), .IN_W(18), .OUT_W(16), .SHIFT(2), .CNT_W(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .relu_en(relu_en), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_data(out_data_s), .sat_cnt(sat_cnt_s), .sat_clr(sat_clr));

  sat_round_narrow #(.LANES(4), .IN_W(18), .OUT_W(16), .SHIFT(0), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_data(in_data), .relu_en(relu_en), .out_valid(out_valid_c),
    .out_ready(out_ready), .out_data(out_data_c), .sat_cnt(sat_cnt_c), .sat_clr(sat_clr));

  always #5 clk = ~clk;

  // Sole driver of out_ready: random when enabled, else the forced level.
  always @(posedge clk) begin
    #2;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Reference model: round-half-up shift, clamp to 16 bits, then ReLU.
  function automatic logic [63:0] model(input logic [71:0] din, input logic relu,
                                        input int shift, output int nsat);
    logic [63:0] res;
    longint      v;
    res  = '0;
    nsat = 0;
    for (int k = 0; k < 4; k++) begin
      v = longint'($signed(din[k*18 +: 18]));
      v = (v + ((longint'(1) << shift) >>> 1)) >>> shift;
      if (v > 32767) begin
        v = 32767;
        nsat++;
      end else if (v < -32768) begin
        v = -32768;
        nsat++;
      end
      if (relu && v < 0) v = 0;
      res[k*16 +: 16] = v[15:0];
    end
    return res;
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (held && out_valid0 === 1'b1) begin
      n_checks++;
      if (out_data0 !== held_d)
        $display("[TB] FAIL stall_hold out_data=%h required=%h", out_data0, held_d);
      else
        n_pass++;
    end
    if (out_valid0 === 1'b1 && out_ready === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("[TB] FAIL unexpected_output out_data=%h required=no word", out_data0);
      end else begin
        mon_e = sb.pop_front();
        n_out++;
        if (out_data0 !== mon_e.d0 || out_data_c !== mon_e.d0 || out_data_s !== mon_e.d2 ||
            out_valid_s !== 1'b1 || out_valid_c !== 1'b1)
          $display("[TB] FAIL out_word d0=%h dc=%h ds=%h vs=%b vc=%b required d0=%h ds=%h",
                   out_data0, out_data_c, out_data_s, out_valid_s, out_valid_c,
                   mon_e.d0, mon_e.d2);
        else
          n_pass++;
      end
    end
    held   = (out_valid0 === 1'b1 && out_ready === 1'b0);
    held_d = out_data0;
  end

  // Present a word at posedge+1 and hold it until it is accepted.
  task automatic send(input logic [71:0] d, input logic r);
    int   ns0, ns2;
    exp_t e;
    bit   ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    relu_en  = r;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready0 === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok || in_ready_s !== 1'b1 || in_ready_c !== 1'b1) begin
      $display("[TB] FAIL send_accept in_ready=%b/%b/%b required=1/1/1",
               in_ready0, in_ready_s, in_ready_c);
    end else begin
      n_pass++;
      e.d0 = model(d, r, 0, ns0);
      e.d2 = model(d, r, 2, ns2);
      sb.push_back(e);
      cnt0  = (cnt0 + ns0 > 65535) ? 65535 : cnt0 + ns0;
      cnt_s = (cnt_s + ns2 > 65535) ? 65535 : cnt_s + ns2;
      cnt_c = (cnt_c + ns0 > 3) ? 3 : cnt_c + ns0;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok          = 1'b0;
    rand_ready  = 1'b0;
    ready_force = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && out_valid0 === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) $display("[TB] FAIL drain pending=%0d required=0", sb.size());
    else     n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    cnt0 = 0; cnt_s = 0; cnt_c = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; relu_en = 1'b0; sat_clr = 1'b0;
    ready_force = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid0 !== 1'b0 || out_data0 !== 64'd0 || sat_cnt0 !== 16'd0 || sat_cnt_c !== 2'd0)
      $display("[TB] FAIL reset_state valid=%b data=%h cnt=%h/%h required 0,0,0,0",
               out_valid0, out_data0, sat_cnt0, sat_cnt_c);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready0 !== 1'b1) $display("[TB] FAIL ready_after_reset in_ready=%b required=1", in_ready0);
    else n_pass++;
    ready_force = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_defaults();
    send({18'h00123, 18'h3FFFF, 18'h20000, 18'h1FFFF}, 1'b0);
    n_checks++;
    if (out_valid0 !== 1'b0) $display("[TB] FAIL latency_early out_valid=%b required=0", out_valid0);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== {16'h0123, 16'hFFFF, 16'h8000, 16'h7FFF})
      $display("[TB] FAIL default_word valid=%b data=%h required 1,%h", out_valid0, out_data0,
               {16'h0123, 16'hFFFF, 16'h8000, 16'h7FFF});
    else n_pass++;
    n_checks++;
    if (sat_cnt0 !== 16'(cnt0) || sat_cnt0 !== 16'd2)
      $display("[TB] FAIL default_cnt sat_cnt=%0d required=2", sat_cnt0);
    else n_pass++;
    drain();
  endtask

  task automatic test_round_shift();
    send({18'h3FFFE, 18'h00005, 18'h3FFFA, 18'h00006}, 1'b0);
    @(posedge clk);
    #1;
    n_checks++;
    if (out_data_s !== {16'h0000, 16'h0001, 16'hFFFF, 16'h0002})
      $display("[TB] FAIL round_shift data=%h required=%h", out_data_s,
               {16'h0000, 16'h0001, 16'hFFFF, 16'h0002});
    else n_pass++;
    drain();
  endtask

  task automatic test_relu();
    send({18'h1FFFF, 18'h00005, 18'h20000, 18'h3FFFF}, 1'b1);
    @(posedge clk);
    #1;
    n_checks++;
    if (out_data0 !== {16'h7FFF, 16'h0005, 16'h0000, 16'h0000} || sat_cnt0 !== 16'(cnt0))
      $display("[TB] FAIL relu data=%h cnt=%0d required %h,%0d", out_data0, sat_cnt0,
               {16'h7FFF, 16'h0005, 16'h0000, 16'h0000}, cnt0);
    else n_pass++;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [71:0] d;
    time         t0;
    t0 = $time;
    for (int i = 0; i < 6; i++) begin
      d[31:0] = $urandom; d[63:32] = $urandom; d[71:64] = 8'($urandom);
      send(d, 1'($urandom_range(0, 1)));
    end
    n_checks++;
    if ($time - t0 != 60) $display("[TB] FAIL throughput elapsed=%0t required=60", $time - t0);
    else n_pass++;
    drain();
  endtask

  task automatic test_random_stall();
    logic [71:0] d;
    int          n0;
    n0 = n_out;
    rand_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d[31:0] = $urandom; d[63:32] = $urandom; d[71:64] = 8'($urandom);
      send(d, 1'($urandom_range(0, 1)));
    end
    drain();
    n_checks++;
    if (n_out - n0 != 8) $display("[TB] FAIL stream_count words=%0d required=8", n_out - n0);
    else n_pass++;
    n_checks++;
    if (sat_cnt0 !== 16'(cnt0) || sat_cnt_s !== 16'(cnt_s) || sat_cnt_c !== 2'(cnt_c))
      $display("[TB] FAIL stall_cnt cnt=%0d/%0d/%0d required %0d/%0d/%0d",
               sat_cnt0, sat_cnt_s, sat_cnt_c, cnt0, cnt_s, cnt_c);
    else n_pass++;
  endtask

  task automatic test_cnt_saturate();
    pulse_clr();
    n_checks++;
    if (sat_cnt0 !== 16'd0 || sat_cnt_c !== 2'd0)
      $display("[TB] FAIL clr_idle cnt=%0d/%0d required 0/0", sat_cnt0, sat_cnt_c);
    else n_pass++;
    for (int i = 0; i < 3; i++) send({4{18'h1FFFF}}, 1'b0);
    drain();
    n_checks++;
    if (sat_cnt_c !== 2'd3 || sat_cnt0 !== 16'(cnt0))
      $display("[TB] FAIL cnt_sat cnt_c=%0d cnt0=%0d required 3,%0d", sat_cnt_c, sat_cnt0, cnt0);
    else n_pass++;
    send({4{18'h20000}}, 1'b0);
    drain();
    n_checks++;
    if (sat_cnt_c !== 2'd3) $display("[TB] FAIL cnt_hold cnt_c=%0d required=3", sat_cnt_c);
    else n_pass++;
    send({4{18'h1FFFF}}, 1'b0);
    pulse_clr();
    n_checks++;
    if (sat_cnt0 !== 16'd0 || sat_cnt_s !== 16'd0 || sat_cnt_c !== 2'd0)
      $display("[TB] FAIL clr_priority cnt=%0d/%0d/%0d required 0/0/0",
               sat_cnt0, sat_cnt_s, sat_cnt_c);
    else n_pass++;
    drain();
    n_checks++;
    if (sat_cnt0 !== 16'd0) $display("[TB] FAIL clr_after_drain cnt=%0d required=0", sat_cnt0);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    ready_force = 1'b0;
    send({4{18'h1FFFF}}, 1'b0);
    send({4{18'h00042}}, 1'b0);
    #1;
    n_checks++;
    if (out_valid0 !== 1'b1) $display("[TB] FAIL full_before_reset out_valid=%b required=1", out_valid0);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid0 !== 1'b0 || out_data0 !== 64'd0 || sat_cnt0 !== 16'd0)
      $display("[TB] FAIL async_reset valid=%b data=%h cnt=%0d required 0,0,0",
               out_valid0, out_data0, sat_cnt0);
    else n_pass++;
    sb.delete();
    cnt0 = 0; cnt_s = 0; cnt_c = 0;
    rst_n = 1'b1;
    ready_force = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid0 !== 1'b0) $display("[TB] FAIL stale_word out_valid=%b required=0", out_valid0);
      else n_pass++;
    end
    @(posedge clk);
    #1;
    send({18'h00001, 18'h3FFFF, 18'h1FFFF, 18'h00100}, 1'b0);
    drain();
    n_checks++;
    if (sat_cnt0 !== 16'(cnt0)) $display("[TB] FAIL post_reset_cnt cnt=%0d required=%0d", sat_cnt0, cnt0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_round_shift();
    test_relu();
    test_back_to_back();
    test_random_stall();
    test_cnt_saturate();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time=%0t required=finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
